// File: rtl/dist32.sv
// 32-lane pipelined multicast tree: one word per cycle is replicated through five
// registered levels (1,2,4,8,16 nodes) into per-lane output registers.
module dist32 #(
  parameter int unsigned DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [31:0]        in_mask,
  output logic [31:0]        out_valid,
  input  logic [31:0]        out_ready,
  output logic [32*DW-1:0]   out_data,
  output logic               busy,
  output logic [31:0]        cnt_accept,
  output logic [31:0]        cnt_drop
);

  localparam int unsigned LANES = 32;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned MAXN  = 16;

  // The sub-masks of all nodes on one level concatenate to a LANES-bit vector in lane
  // order, so a level's mask passes down unchanged; only the data is replicated.
  logic [LANES-1:0] mask_q [DEPTH];
  logic [LANES-1:0] mask_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH][MAXN];
  logic [DW-1:0]    data_d [DEPTH][MAXN];

  logic [LANES-1:0] out_valid_q, out_valid_d;
  logic [DW-1:0]    lane_q [LANES];
  logic [DW-1:0]    lane_d [LANES];
  logic [31:0]      cnt_accept_q, cnt_accept_d;
  logic [31:0]      cnt_drop_q, cnt_drop_d;

  logic blocked;
  logic advance;
  logic fire;

  always_comb begin
    blocked = |(mask_q[DEPTH-1] & out_valid_q & ~out_ready);
    advance = ~blocked;
    fire    = in_valid & advance;

    mask_d       = mask_q;
    data_d       = data_q;
    out_valid_d  = out_valid_q;
    lane_d       = lane_q;
    cnt_accept_d = cnt_accept_q;
    cnt_drop_d   = cnt_drop_q;

    if (advance) begin
      mask_d[0] = fire ? in_mask : '0;
      data_d[0][0] = in_data;
      for (int unsigned l = 1; l < DEPTH; l++) begin
        mask_d[l] = mask_q[l-1];
        for (int unsigned n = 0; n < MAXN; n++) begin
          if (n < (32'd1 << l)) data_d[l][n] = data_q[l-1][n >> 1];
        end
      end
    end

    // A targeted lane reloads even if it is being consumed this same cycle.
    for (int unsigned i = 0; i < LANES; i++) begin
      if (advance && mask_q[DEPTH-1][i]) begin
        out_valid_d[i] = 1'b1;
        lane_d[i]      = data_q[DEPTH-1][i >> 1];
      end else if (out_valid_q[i] && out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end

    if (fire) begin
      cnt_accept_d = cnt_accept_q + 32'd1;
      if (in_mask == '0) cnt_drop_d = cnt_drop_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned l = 0; l < DEPTH; l++) begin
        mask_q[l] <= '0;
        for (int unsigned n = 0; n < MAXN; n++) data_q[l][n] <= '0;
      end
      out_valid_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
      cnt_accept_q <= '0;
      cnt_drop_q   <= '0;
    end else begin
      mask_q       <= mask_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      lane_q       <= lane_d;
      cnt_accept_q <= cnt_accept_d;
      cnt_drop_q   <= cnt_drop_d;
    end
  end

  always_comb begin
    busy = |out_valid_q;
    for (int unsigned l = 0; l < DEPTH; l++) busy = busy | (|mask_q[l]);
    out_data = '0;
    for (int unsigned i = 0; i < LANES; i++) out_data[i*DW +: DW] = lane_q[i];
  end

  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign cnt_accept = cnt_accept_q;
  assign cnt_drop   = cnt_drop_q;

endmodule

// File: tb/tb_dist32.sv
// Self-checking bench for dist32: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dist32;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [31:0]     in_mask;
  logic [31:0]     out_valid;
  logic [31:0]     out_ready;
  logic [32*DW-1:0] out_data;
  logic            busy;
  logic [31:0]     cnt_accept;
  logic [31:0]     cnt_drop;

  always #5 clk = ~clk;

  dist32 #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .cnt_accept (cnt_accept),
    .cnt_drop   (cnt_drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_of(input int i);
    return out_data[i*DW +: DW];
  endfunction

  // Reference model: in-flight words with the tree level they occupy (1..5), plus lanes.
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] m;
    logic [2:0]  stage;
  } ent_t;

  ent_t        q[$];
  logic [31:0] lv;
  logic [31:0] ld [32];
  logic [31:0] acc, drp;
  bit          model_ok = 0;

  always @(negedge clk) begin
    logic blk, adv, fire, deliver;
    ent_t e;
    blk = 1'b0;
    if (q.size() > 0 && q[0].stage == 3'd5) blk = |(q[0].m & lv & ~out_ready);
    if (model_ok) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !blk});
      chk("out_valid", {32'd0, out_valid}, {32'd0, lv});
      for (int i = 0; i < 32; i++) chk($sformatf("lane%0d_data", i), {32'd0, lane_of(i)}, {32'd0, ld[i]});
      chk("busy", {63'd0, busy}, {63'd0, (q.size() > 0) || (lv != 0)});
      chk("cnt_accept", {32'd0, cnt_accept}, {32'd0, acc});
      chk("cnt_drop", {32'd0, cnt_drop}, {32'd0, drp});
    end
    if (rst) begin
      q.delete();
      lv = '0;
      for (int i = 0; i < 32; i++) ld[i] = '0;
      acc = '0;
      drp = '0;
      model_ok = 1;
    end else if (model_ok) begin
      adv = !blk;
      fire = in_valid && adv;
      deliver = adv && q.size() > 0 && q[0].stage == 3'd5;
      for (int i = 0; i < 32; i++) begin
        if (deliver && q[0].m[i]) begin
          lv[i] = 1'b1;
          ld[i] = q[0].d;
        end else if (lv[i] && out_ready[i]) begin
          lv[i] = 1'b0;
        end
      end
      if (adv) begin
        if (deliver) void'(q.pop_front());
        for (int k = 0; k < q.size(); k++) q[k].stage = q[k].stage + 3'd1;
        if (fire && in_mask != 0) begin
          e.d = in_data;
          e.m = in_mask;
          e.stage = 3'd1;
          q.push_back(e);
        end
      end
      if (fire) acc = acc + 32'd1;
      if (fire && in_mask == 0) drp = drp + 32'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rmode;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mask = '0;
    out_ready = '1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_out_valid", {32'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    // Broadcast
    in_valid = 1'b1; in_data = 32'hA5A5_0001; in_mask = 32'hFFFF_FFFF;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    chk("bc_valid_c6", {32'd0, out_valid}, 64'hFFFF_FFFF);
    chk("bc_lane0", {32'd0, lane_of(0)}, 64'hA5A5_0001);
    chk("bc_lane31", {32'd0, lane_of(31)}, 64'hA5A5_0001);
    chk("bc_accept", {32'd0, cnt_accept}, 64'd1);
    cyc();
    chk("bc_valid_c7", {32'd0, out_valid}, 64'd0);
    cyc();

    // Streaming unicast
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = k; in_mask = 32'd1 << k;
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (5) cyc();
    chk("stream_busy_c37", {63'd0, busy}, 64'd1);
    chk("stream_lane31", {32'd0, lane_of(31)}, 64'd31);
    cyc();
    chk("stream_busy_c38", {63'd0, busy}, 64'd0);
    cyc();

    // Backpressure on lane 3
    out_ready = ~32'h8;
    in_valid = 1'b1; in_mask = 32'h8;
    in_data = 32'h1111_0001; cyc();
    in_data = 32'h2222_0002; cyc();
    in_data = 32'h3333_0003; cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("bp_ready_c6", {63'd0, in_ready}, 64'd0);
    chk("bp_lane3_c6", {32'd0, lane_of(3)}, 64'h1111_0001);
    repeat (4) cyc();
    chk("bp_ready_c10", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_c10", {32'd0, lane_of(3)}, 64'h1111_0001);
    out_ready = '1;
    cyc();
    chk("bp_lane3_c11", {32'd0, lane_of(3)}, 64'h2222_0002);
    chk("bp_valid_c11", {32'd0, out_valid}, 64'h8);
    cyc();
    chk("bp_lane3_c12", {32'd0, lane_of(3)}, 64'h3333_0003);
    cyc();
    chk("bp_valid_c13", {32'd0, out_valid}, 64'd0);
    chk("bp_busy_c13", {63'd0, busy}, 64'd0);

    // Non-blocking lane 7
    out_ready = ~32'h80;
    in_valid = 1'b1; in_data = 32'h7777_7777; in_mask = 32'h80;
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 32'h100 + k; in_mask = 32'h1;
      chk("nb_ready", {63'd0, in_ready}, 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("nb_lane7_held", {32'd0, out_valid}, 64'h80);
    out_ready = '1;
    cyc();

    // Zero masks interleaved with lane-31 words
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = 32'hC0DE_0000 + k;
      in_mask = k[0] ? 32'h8000_0000 : 32'h0;
      chk("zm_lanes", {32'd0, out_valid & 32'h7FFF_FFFF}, 64'd0);
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) begin
      chk("zm_lanes", {32'd0, out_valid & 32'h7FFF_FFFF}, 64'd0);
      cyc();
    end
    chk("zm_drop", {32'd0, cnt_drop}, 64'd4);
    chk("zm_accept", {32'd0, cnt_accept}, 64'd8);

    // Reset mid-flight
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'hDEAD_0000 + k; in_mask = 32'hF0F0_0F0F;
      cyc();
    end
    in_valid = 1'b0;
    do_reset();
    chk("rst_valid", {32'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_accept", {32'd0, cnt_accept}, 64'd0);
    chk("rst_drop", {32'd0, cnt_drop}, 64'd0);
    repeat (10) begin
      cyc();
      chk("rst_no_stale", {32'd0, out_valid}, 64'd0);
    end

    // Randomized traffic
    rmode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) rmode = $urandom_range(0, 2);
      in_valid = ($urandom % 4) != 0;
      in_data = $urandom;
      case ($urandom % 6)
        0: in_mask = $urandom;
        1: in_mask = 32'd1 << ($urandom % 32);
        2: in_mask = 32'hFFFF_FFFF;
        3: in_mask = 32'h0;
        4: in_mask = $urandom & $urandom & $urandom;
        default: in_mask = 32'd3 << (2 * ($urandom % 16));
      endcase
      case (rmode)
        0: out_ready = '1;
        1: out_ready = $urandom;
        default: out_ready = ~($urandom & $urandom & $urandom);
      endcase
      rst = ($urandom % 500) == 0;
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = '1;
    repeat (10) cyc();
    chk("final_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist32.md
Name: dist32

Overview:
- 32-lane pipelined distribution (multicast/scatter) tree; the forward-direction counterpart of the fan32/reduce32 reduction networks.
- Accepts one DW-bit word per cycle with a 32-bit destination mask and replicates it down a registered binary tree (1→2→4→8→16 nodes) into per-lane output registers.
- Sits between the operand buffer and the multiplier/lane array that feeds the fan/reduce networks.

Parameters:
DW, 32, data word width per lane
LANES, 32, lane count; fixed at 32 (tree depth 5), not a free parameter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  dist32 can accept input this cycle
in_data  input  DW  word to distribute
in_mask  input  32  destination lanes; bit i = deliver to lane i
out_valid  output  32  per-lane output valid
out_ready  input  32  per-lane consumer ready
out_data  output  32*DW  lane i data at bits [i*DW +: DW]
busy  output  1  any tree node or lane register valid
cnt_accept  output  32  words accepted (in_valid & in_ready), wraps at 2^32
cnt_drop  output  32  accepted words with in_mask == 0, wraps at 2^32

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). Reset clears all node/lane valids, out_valid = 0, out_data = 0, cnt_accept = cnt_drop = 0, busy = 0. Reset mid-operation discards all in-flight words; no delivery after reset.
- Tree: level k (k = 1..5) has 2^(k-1) nodes. Each node holds data and a sub-mask covering 32/2^(k-1) contiguous lanes. Node valid = OR of its sub-mask. Level-5 node j covers lanes 2j and 2j+1. Lane register i is level 6.
- Pass-down: on advance, each child takes the parent's data and the half of the parent's sub-mask it covers. Lower half goes to the even child, upper half to the odd child. A child whose half-mask is zero becomes invalid; its data is don't-care.
- Accept: fire = in_valid & in_ready. On fire, level 1 loads in_data and in_mask. in_mask == 0: level 1 stays invalid, cnt_drop increments.
- Latency: fire in cycle 0 → out_valid[i] = 1 in cycle 6 for every mask bit i, with no backpressure. Throughput is 1 word/cycle.
- Backpressure: a single global stall. blocked = OR over i of (lvl5 targets lane i & out_valid[i] & ~out_ready[i]). advance = ~blocked. in_ready = advance. When stalled, all tree levels hold, including valid bubbles.
- Lane register i:
  - if advance & lvl5 targets i: load data and set valid, even if currently consumed in the same cycle (back-to-back allowed);
  - else if out_valid[i] & out_ready[i]: clear valid;
  - else hold.
- Lanes not targeted are never stalled by others. A non-targeted lane holding data does not block the pipe.
- Ordering: per lane, words arrive in acceptance order; no loss, no duplication.
- out_data is held stable while out_valid[i] & ~out_ready[i].
- in_ready may be high while in_valid is low; bubbles propagate as invalid nodes.
- Counters wrap modulo 2^32 silently.
- busy is combinational OR of all valids.

Test Plan:
- Broadcast: out_ready = all-ones, one word 0xA5A5_0001, mask 0xFFFF_FFFF at cycle 0 → out_valid = 0xFFFF_FFFF in cycle 6, all 32 lanes = 0xA5A5_0001, cleared cycle 7; cnt_accept = 1.
- Streaming unicast: words 0..31 with mask = 1<<k on consecutive cycles, out_ready all-ones → lane k sees word k in cycle k+6; in_ready constantly 1; busy falls in cycle 38.
- Backpressure: out_ready[3] = 0, send 3 words each masked 0x0000_0008 → first lands lane 3; second stalls at level 5, in_ready falls. Release out_ready[3] → remaining 2 words delivered in order, one per cycle; other lanes unaffected.
- Non-blocking lane: lane 7 holds a word with out_ready[7] = 0, stream mask 0x0000_0001 → lane 0 receives every word at full rate, in_ready stays 1.
- Zero mask: mask 0 words interleaved with mask 0x8000_0000 words → only lane 31 outputs; cnt_drop counts the zeros exactly.
- Reset mid-flight: 4 words in tree, assert rst 1 cycle → next cycle out_valid = 0, busy = 0, counters = 0; no stale output in the following 10 cycles.
